// File: rtl/fwd_sel_ctrl_if.sv
// fwd_sel_ctrl_if: bundle between the ID-stage decode/hazard logic and the
// EX operand-forwarding controller.
//   master : ID side. Drives id_* fields and flush; receives the selects,
//            stall and the shadow destination registers.
//   slave  : forwarding controller (fwd_sel_ctrl).
// Signals:
//   id_valid, id_rs, id_rt, id_dst, id_we, id_load, flush : ID instruction
//   sel_a, sel_b  : registered 2-bit ALU operand mux selects
//   stall         : combinational load-use stall
//   ex_dst, mem_dst, wb_dst : shadow destination registers
interface fwd_sel_ctrl_if #(
  parameter int RA_W = 5
);
  logic            id_valid;
  logic [RA_W-1:0] id_rs;
  logic [RA_W-1:0] id_rt;
  logic [RA_W-1:0] id_dst;
  logic            id_we;
  logic            id_load;
  logic            flush;
  logic [1:0]      sel_a;
  logic [1:0]      sel_b;
  logic            stall;
  logic [RA_W-1:0] ex_dst;
  logic [RA_W-1:0] mem_dst;
  logic [RA_W-1:0] wb_dst;

  modport master (
    output id_valid, id_rs, id_rt, id_dst, id_we, id_load, flush,
    input  sel_a, sel_b, stall, ex_dst, mem_dst, wb_dst
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_dst, id_we, id_load, flush,
    output sel_a, sel_b, stall, ex_dst, mem_dst, wb_dst
  );
endinterface

// File: rtl/fwd_sel_ctrl.sv
// fwd_sel_ctrl: EX-stage ALU operand forwarding select generator.
// Tracks a shadow of the destination/write-enable of the instructions in EX,
// MEM and WB, decides each operand's forwarding source while the consumer is
// still in ID, and registers the selects on the edge that moves it into EX.
// Raises a one-cycle load-use stall (bubble into EX) when needed.
//
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : fwd_sel_ctrl_if.slave (ID fields, flush, sel_a/sel_b, stall,
//            ex_dst/mem_dst/wb_dst)
// Select codes: 00 regfile, 01 EX/MEM ALU, 10 MEM/WB data, 11 WB bypass latch.
//
// Build option: FWD_SEL_WB_BYPASS_EN
//   defined   - a WB-stage match selects 11 (external last-write latch).
//   undefined - register file is write-first; WB matches select 00 and
//               code 11 is never produced.
module fwd_sel_ctrl #(
  parameter int RA_W     = 5,
  parameter int ZERO_REG = 0
) (
  input logic          clk,
  input logic          rst_n,
  fwd_sel_ctrl_if.slave bus
);

  localparam logic [RA_W-1:0] ZR = RA_W'(ZERO_REG);

  // Only EX needs the load flag (load-use check); the WB write-enable only
  // matters when the bypass latch exists.
  logic [RA_W-1:0] ex_dst_q, mem_dst_q, wb_dst_q;
  logic            ex_we_q, ex_load_q, mem_we_q;
`ifdef FWD_SEL_WB_BYPASS_EN
  logic            wb_we_q;
`endif

  logic       stall_c;
  logic       adv;
  logic [1:0] sel_a_d, sel_b_d;
  logic [1:0] sel_a_q, sel_b_q;

  // Youngest producer wins: EX beats MEM beats WB.
  function automatic logic [1:0] fwd_code(input logic [RA_W-1:0] s);
    logic [1:0] c;
    c = 2'b00;
    if (s == ZR)
      c = 2'b00;
    else if (ex_we_q && ex_dst_q == s)
      c = 2'b01;
    else if (mem_we_q && mem_dst_q == s)
      c = 2'b10;
`ifdef FWD_SEL_WB_BYPASS_EN
    else if (wb_we_q && wb_dst_q == s)
      c = 2'b11;
`endif
    return c;
  endfunction

  always_comb begin
    stall_c = bus.id_valid & ~bus.flush & ex_load_q & ex_we_q &
              (ex_dst_q != ZR) &
              ((ex_dst_q == bus.id_rs) | (ex_dst_q == bus.id_rt));
    adv     = bus.id_valid & ~stall_c & ~bus.flush;
    sel_a_d = fwd_code(bus.id_rs);
    sel_b_d = fwd_code(bus.id_rt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_dst_q  <= '0;
      ex_we_q   <= 1'b0;
      ex_load_q <= 1'b0;
      mem_dst_q <= '0;
      mem_we_q  <= 1'b0;
      wb_dst_q  <= '0;
`ifdef FWD_SEL_WB_BYPASS_EN
      wb_we_q   <= 1'b0;
`endif
      sel_a_q   <= '0;
      sel_b_q   <= '0;
    end else begin
      wb_dst_q  <= mem_dst_q;
`ifdef FWD_SEL_WB_BYPASS_EN
      wb_we_q   <= mem_we_q;
`endif
      mem_dst_q <= ex_dst_q;
      mem_we_q  <= ex_we_q;
      if (adv) begin
        ex_dst_q  <= bus.id_dst;
        ex_we_q   <= bus.id_we;
        ex_load_q <= bus.id_load;
        sel_a_q   <= sel_a_d;
        sel_b_q   <= sel_b_d;
      end else begin
        ex_dst_q  <= '0;
        ex_we_q   <= 1'b0;
        ex_load_q <= 1'b0;
        sel_a_q   <= '0;
        sel_b_q   <= '0;
      end
    end
  end

  assign bus.sel_a   = sel_a_q;
  assign bus.sel_b   = sel_b_q;
  assign bus.stall   = stall_c;
  assign bus.ex_dst  = ex_dst_q;
  assign bus.mem_dst = mem_dst_q;
  assign bus.wb_dst  = wb_dst_q;

endmodule

// File: tb/tb_fwd_sel_ctrl.sv
module tb_fwd_sel_ctrl;

`ifdef FWD_SEL_WB_BYPASS_EN
  localparam logic [1:0] WB_CODE = 2'b11;
`else
  localparam logic [1:0] WB_CODE = 2'b00;
`endif

  logic clk;
  logic rst_n;
  int   total;
  int   passed;

  fwd_sel_ctrl_if #(.RA_W(5)) bus ();

  fwd_sel_ctrl #(.RA_W(5), .ZERO_REG(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] dst, input logic we, input logic ld,
                        input logic fl);
    bus.id_valid = v;
    bus.id_rs    = rs;
    bus.id_rt    = rt;
    bus.id_dst   = dst;
    bus.id_we    = we;
    bus.id_load  = ld;
    bus.flush    = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst_n  = 1'b0;
    set_id(1'b1, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b0);
    #3;
    chk("rst_sel_a", bus.sel_a, 2'b00);
    chk("rst_sel_b", bus.sel_b, 2'b00);
    chk("rst_stall", bus.stall, 1'b0);
    chk("rst_ex_dst", bus.ex_dst, 5'd0);
    chk("rst_mem_dst", bus.mem_dst, 5'd0);
    chk("rst_wb_dst", bus.wb_dst, 5'd0);
    #9 rst_n = 1'b1;

    // back-to-back ALU: add r3 ; sub r8 = r3, r4
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    chk("b2b_ex_dst", bus.ex_dst, 5'd3);
    set_id(1'b1, 5'd3, 5'd4, 5'd8, 1'b1, 1'b0, 1'b0);
    #1 chk("b2b_stall", bus.stall, 1'b0);
    tick();
    chk("b2b_sel_a", bus.sel_a, 2'b01);
    chk("b2b_sel_b", bus.sel_b, 2'b00);

    // distance 2: add r5 ; nop ; or r10 = r5, r9
    set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("d2_mem_dst", bus.mem_dst, 5'd5);
    set_id(1'b1, 5'd5, 5'd9, 5'd10, 1'b1, 1'b0, 1'b0);
    tick();
    chk("d2_sel_a", bus.sel_a, 2'b10);
    chk("d2_sel_b", bus.sel_b, 2'b00);

    // load-use: lw r7 ; add r11 = r1, r7
    set_id(1'b1, 5'd1, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd1, 5'd7, 5'd11, 1'b1, 1'b0, 1'b0);
    #1 chk("lu_stall", bus.stall, 1'b1);
    tick();
    chk("lu_bub_sel_a", bus.sel_a, 2'b00);
    chk("lu_bub_sel_b", bus.sel_b, 2'b00);
    chk("lu_bub_ex_dst", bus.ex_dst, 5'd0);
    chk("lu_stall_drop", bus.stall, 1'b0);
    tick();
    chk("lu_sel_b", bus.sel_b, 2'b10);
    chk("lu_sel_a", bus.sel_a, 2'b00);
    chk("lu_ex_dst", bus.ex_dst, 5'd11);

    // priority: add r2 ; add r2 ; use r2
    set_id(1'b1, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    set_id(1'b1, 5'd2, 5'd12, 5'd13, 1'b1, 1'b0, 1'b0);
    tick();
    chk("prio_sel_a", bus.sel_a, 2'b01);
    chk("prio_sel_b", bus.sel_b, 2'b00);

    // zero register: writer dst r0 ; consumer r0, r0
    set_id(1'b1, 5'd1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 5'd14, 1'b1, 1'b0, 1'b0);
    tick();
    chk("zero_sel_a", bus.sel_a, 2'b00);
    chk("zero_sel_b", bus.sel_b, 2'b00);

    // flush beats stall: lw r6 ; consumer of r6 with flush
    set_id(1'b1, 5'd1, 5'd0, 5'd6, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd6, 5'd6, 5'd15, 1'b1, 1'b0, 1'b1);
    #1 chk("fl_stall", bus.stall, 1'b0);
    tick();
    chk("fl_ex_dst", bus.ex_dst, 5'd0);
    chk("fl_sel_a", bus.sel_a, 2'b00);

    // load into r0 never stalls
    set_id(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 5'd3, 5'd16, 1'b1, 1'b0, 1'b0);
    #1 chk("ld0_stall", bus.stall, 1'b0);

    // distance 3: add r9 ; nop ; nop ; use r9, r9
    set_id(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0);
    tick();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk("d3_wb_dst", bus.wb_dst, 5'd9);
    set_id(1'b1, 5'd9, 5'd9, 5'd17, 1'b1, 1'b0, 1'b0);
    tick();
    chk("d3_sel_a", bus.sel_a, WB_CODE);
    chk("d3_sel_b", bus.sel_b, WB_CODE);

    // asynchronous reset mid-sequence
    set_id(1'b1, 5'd1, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 5'd4, 5'd4, 5'd18, 1'b1, 1'b0, 1'b0);
    tick();
    chk("pre_rst_sel_a", bus.sel_a, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sel_a", bus.sel_a, 2'b00);
    chk("arst_sel_b", bus.sel_b, 2'b00);
    chk("arst_ex_dst", bus.ex_dst, 5'd0);
    chk("arst_mem_dst", bus.mem_dst, 5'd0);
    chk("arst_stall", bus.stall, 1'b0);
    #2 rst_n = 1'b1;
    tick();
    chk("post_rst_sel_a", bus.sel_a, 2'b00);
    chk("post_rst_sel_b", bus.sel_b, 2'b00);
    chk("post_rst_ex_dst", bus.ex_dst, 5'd18);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
